// File: rtl/seq_pkg.sv
// Shared types and helpers for the staggered enable sequencer.
`default_nettype none

package seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } seq_state_t;

  // Gap counter width; a single-cycle stagger still needs one bit.
  function automatic int gap_width(input int stagger_cycles);
    int w;
    w = $clog2(stagger_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stagger_gap_timer.sv
// Saturating counter of edges since the last group_en change; permit
// is high once the minimum spacing has elapsed.
`default_nettype none

module stagger_gap_timer
  import seq_pkg::*;
#(
  parameter int STAGGER_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic change,
  output logic permit
);

  localparam int GAP_W = gap_width(STAGGER_CYCLES);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(STAGGER_CYCLES - 1);

  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_d;

  always_comb begin
    gap_d = gap_q;
    if (change) begin
      gap_d = '0;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + 1'b1;
    end
  end

  // Reset into the saturated value so the first command acts at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= GAP_MAX;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign permit = (gap_q == GAP_MAX);

endmodule

`default_nettype wire

// File: rtl/staggered_enable_sequencer.sv
// Ramps a thermometer-coded group enable up/down one group at a time,
// spacing consecutive changes by at least STAGGER_CYCLES edges.
`default_nettype none

module staggered_enable_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_GROUPS     = 4,
  parameter int STAGGER_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  output logic [NUM_GROUPS-1:0] group_en,
  output logic                  busy,
  output logic                  all_on,
  output logic                  up_done,
  output logic                  down_done
);

  seq_state_t state_q, state_d;
  logic [NUM_GROUPS-1:0] en_q, en_d;
  logic busy_q, busy_d;
  logic all_on_q, all_on_d;
  logic up_done_q, up_done_d;
  logic down_done_q, down_done_d;

  logic [NUM_GROUPS-1:0] en_set;
  logic [NUM_GROUPS-1:0] en_clr;
  logic                  permit;
  logic                  change;

  assign en_set = {en_q[NUM_GROUPS-2:0], 1'b1};
  assign en_clr = {1'b0, en_q[NUM_GROUPS-1:1]};
  assign change = (en_d != en_q);

  stagger_gap_timer #(
    .STAGGER_CYCLES (STAGGER_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .change (change),
    .permit (permit)
  );

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    up_done_d   = 1'b0;
    down_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RAMP_UP;
          if (permit) en_d = en_set;
        end
      end
      RAMP_UP: begin
        if (stop) begin
          state_d = RAMP_DOWN;
          if (permit) en_d = en_clr;
        end else if (permit) begin
          en_d = en_set;
        end
      end
      ON: begin
        if (stop) begin
          state_d = RAMP_DOWN;
          if (permit) en_d = en_clr;
        end
      end
      RAMP_DOWN: begin
        if (start && !stop) begin
          state_d = RAMP_UP;
          if (permit) en_d = en_set;
        end else if (permit) begin
          en_d = en_clr;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ramp endpoints; an empty ramp aborted by stop returns silently.
    if (state_d == RAMP_UP && (&en_d)) begin
      state_d   = ON;
      up_done_d = 1'b1;
    end
    if (state_d == RAMP_DOWN && en_d == '0) begin
      state_d     = IDLE;
      down_done_d = (en_q != '0);
    end

    busy_d   = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
    all_on_d = (state_d == ON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      en_q        <= '0;
      busy_q      <= 1'b0;
      all_on_q    <= 1'b0;
      up_done_q   <= 1'b0;
      down_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      all_on_q    <= all_on_d;
      up_done_q   <= up_done_d;
      down_done_q <= down_done_d;
    end
  end

  assign group_en  = en_q;
  assign busy      = busy_q;
  assign all_on    = all_on_q;
  assign up_done   = up_done_q;
  assign down_done = down_done_q;

endmodule

`default_nettype wire

// File: doc/staggered_enable_sequencer.md
Name: staggered_enable_sequencer

Overview:
- Controller for the buffered output fanout tree. It splits the tree's driven outputs into NUM_GROUPS enable groups and turns them on and off one group at a time.
- Purpose: limit simultaneous switching (ground bounce / inrush) when the cloned-inverter / buffer network is activated or quiesced.
- Position: sits between the top-level control and the per-group output gating cells. Its group_en bits drive those gates directly.

Parameters:
- NUM_GROUPS, 4: number of independently enabled output groups (>=2).
- STAGGER_CYCLES, 3: minimum clock cycles between any two changes of group_en (>=1).
- GAP_W, derived localparam = clog2(STAGGER_CYCLES) (min 1): width of the gap counter. Not user-set.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request ramp-up. Level-sampled each edge.
- stop  input  1  request ramp-down. Level-sampled each edge. Wins over start.
- group_en  output  NUM_GROUPS  per-group enable, thermometer coded from bit 0 upward.
- busy  output  1  high in RAMP_UP or RAMP_DOWN.
- all_on  output  1  high in ON state.
- up_done  output  1  one-cycle pulse when group_en becomes all ones.
- down_done  output  1  one-cycle pulse when group_en becomes zero via ramp-down.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (after the edge with rst=1, from any state, including mid-ramp): state=IDLE, group_en=0, busy=0, all_on=0, up_done=0, down_done=0, gap=STAGGER_CYCLES-1. The saturated gap means the first command acts immediately.
- All outputs are registered.
- group_en is always thermometer code. Only one bit changes per change event: set the lowest zero bit, or clear the highest one bit.

Gap counter:
- Cleared to 0 on any edge where group_en changes.
- Otherwise increments, saturating at STAGGER_CYCLES-1.
- A change is permitted at an edge only if gap==STAGGER_CYCLES-1.
- Therefore consecutive changes are exactly STAGGER_CYCLES edges apart while ramping.
- With STAGGER_CYCLES=1 the gap is always permitted, so one group changes per cycle.

FSM states: IDLE, RAMP_UP, ON, RAMP_DOWN.
- IDLE: stop ignored. start=1 and stop=0 -> go to RAMP_UP.
  - If gap is permitted on that edge (always true from reset), set group_en[0] on the same edge. Latency 1 edge from start to group_en=...0001.
- RAMP_UP:
  - Each permitted edge sets the next bit.
  - The edge that makes group_en all ones -> ON, with all_on=1 and up_done=1 for that cycle.
  - stop=1 -> RAMP_DOWN on that edge. No bit changes on that edge unless gap is permitted, in which case the highest bit is cleared.
  - start is ignored while in RAMP_UP.
- ON: start ignored. stop=1 -> RAMP_DOWN, clearing the top bit on the same edge if gap is permitted.
- RAMP_DOWN:
  - Each permitted edge clears the highest set bit.
  - The edge that makes group_en zero -> IDLE, with down_done=1 for one cycle.
  - start=1 with stop=0 -> RAMP_UP (reversal). The next set obeys gap spacing.
- Reversals never reset the gap counter. The spacing guarantee holds across direction changes.
- start and stop both high: treated as stop in every state.
- up_done and down_done never assert in the same cycle. Neither asserts on reset.

Decomposition:
- Shared package seq_pkg:
  - typedef enum seq_state_t {IDLE, RAMP_UP, ON, RAMP_DOWN}, 2-bit encoding.
  - Localparam helper for the GAP_W computation.
- One sub-module, stagger_gap_timer:
  - Inputs: clk, rst, change.
  - Output: permit.
  - Parameter: STAGGER_CYCLES.
  - Holds the saturating gap counter.
- The FSM and thermometer register live in the top module.

Test Plan (NUM_GROUPS=4, STAGGER_CYCLES=3 unless noted):
- Reset then start=1 sampled at edge k -> group_en = 0001 after k, 0011 after k+3, 0111 after k+6, 1111 after k+9. At k+9: all_on=1, up_done=1 for one cycle. busy=1 from k through k+8.
- From ON, stop at edge m -> group_en = 0111 after m, 0011 after m+3, 0001 after m+6, 0000 after m+9. down_done pulses after m+9. State returns to IDLE.
- Reversal: group_en=0011 set at edge k, stop at edge k+1 -> no change at k+1 or k+2. Top bit cleared at k+3 (0001), 0000 at k+6.
- Simultaneous start=stop=1 in IDLE -> no change. In ON -> ramp-down begins immediately (0111 next edge).
- rst asserted while in RAMP_UP with group_en=0111 -> all outputs 0 after that edge. A subsequent start sets 0001 on the very next edge.
- STAGGER_CYCLES=1: start at edge k -> 0001, 0011, 0111, 1111 on edges k..k+3. up_done pulses after k+3.
